// File: rtl/mult_div_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_MULT   = 2'b01,
        S_DIV    = 2'b10,
        S_FINISH = 2'b11
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    function automatic int md_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int MD_CNT_W = md_cnt_w(MD_DATA_W);

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step
    import mult_div_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_divisor,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qbit
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    // The remainder is always below the divisor, so a DATA_W-bit difference is exact.
    assign w_diff  = w_shift[DATA_W-1:0] - i_divisor;
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff : w_shift[DATA_W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiplier (radix-2 Booth) / restoring divider producing the HI/LO pair.
// Define MULTDIV_UNSIGNED_EN to add the is_unsigned port (MULTU/DIVU semantics).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic              is_unsigned,
`endif
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = md_cnt_w(DATA_W);

    md_state_t                r_state;
    md_state_t                w_next;
    logic [CNT_W-1:0]         r_cnt;

    logic                     w_uns;
    logic                     w_sa;
    logic                     w_sb;
    logic                     w_b_zero;
    logic                     w_last;

    logic                     r_op;
    logic                     r_dz;
    logic                     r_neg_q;
    logic                     r_neg_r;
    logic                     r_bmsb;
    logic                     r_qm1;
    logic signed [DATA_W:0]   r_acc;
    logic signed [DATA_W:0]   r_mcand;
    logic signed [DATA_W:0]   w_sum;
    logic [DATA_W-1:0]        r_mq;

    logic [DATA_W-1:0]        r_rem;
    logic [DATA_W-1:0]        r_dvd;
    logic [DATA_W-1:0]        r_dvs;
    logic [DATA_W-1:0]        w_new_rem;
    logic                     w_qbit;

    logic                     r_busy;
    logic                     r_done;
    logic                     r_div_zero;
    logic [DATA_W-1:0]        r_hi;
    logic [DATA_W-1:0]        r_lo;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

`ifdef MULTDIV_UNSIGNED_EN
    assign w_uns = is_unsigned;
`else
    assign w_uns = 1'b0;
`endif

    assign w_sa     = a[DATA_W-1] & ~w_uns;
    assign w_sb     = b[DATA_W-1] & ~w_uns;
    assign w_b_zero = (b == '0);
    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_DIV) begin
                        w_next = w_b_zero ? S_FINISH : S_DIV;
                    end else begin
                        w_next = S_MULT;
                    end
                end
            end
            S_MULT, S_DIV: begin
                if (w_last) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Booth recoding of the multiplier's low bit pair selects add, subtract or pass.
    always_comb begin
        w_sum = r_acc;
        case ({r_mq[0], r_qm1})
            2'b10:   w_sum = r_acc - r_mcand;
            2'b01:   w_sum = r_acc + r_mcand;
            default: w_sum = r_acc;
        endcase
    end

    div_step #(
        .DATA_W    (DATA_W)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_divisor (r_dvs),
        .i_bit     (r_dvd[DATA_W-1]),
        .o_rem     (w_new_rem),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= OP_MULT;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_bmsb     <= 1'b0;
            r_qm1      <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mq       <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_op    <= op;
                        r_dz    <= (op == OP_DIV) && w_b_zero;
                        r_busy  <= 1'b1;
                        r_mcand <= {a[DATA_W-1] & ~w_uns, a};
                        r_acc   <= '0;
                        r_mq    <= b;
                        r_qm1   <= 1'b0;
                        r_bmsb  <= b[DATA_W-1] & w_uns;
                        r_rem   <= '0;
                        r_dvd   <= neg_if(a, w_sa);
                        r_dvs   <= neg_if(b, w_sb);
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                    end
                end
                S_MULT: begin
                    {r_acc, r_mq, r_qm1} <= {w_sum[DATA_W], w_sum, r_mq};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_rem <= w_new_rem;
                    r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FINISH: begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                    if (!r_dz) begin
                        if (r_op == OP_MULT) begin
                            // Unsigned multiplier with MSB set: Booth weighted it -2^(W-1), add back a*2^W.
                            r_hi <= r_acc[DATA_W-1:0] + (r_bmsb ? r_mcand[DATA_W-1:0] : '0);
                            r_lo <= r_mq;
                        end else begin
                            r_hi <= neg_if(r_rem, r_neg_r);
                            r_lo <= neg_if(r_dvd, r_neg_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random MULT/DIV traffic.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULTDIV_UNSIGNED_EN
    logic        is_uns = 1'b0;
`endif

    mult_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULTDIV_UNSIGNED_EN
        .is_unsigned (is_uns),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic; SV division truncates toward zero
    // and the remainder follows the dividend, which is the MIPS behaviour.
    task automatic push_expect(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               input int k);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        e.dz  = 1'b0;
        e.due = k + 33;
        if (op_i == 1'b0) begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b_i == 32'd0) begin
            e.dz  = 1'b1;
            e.due = k + 1;
        end else begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            m_hi = r[31:0];
            m_lo = q[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input bit push);
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        if (push) push_expect(op_i, a_i, b_i, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 200), 64'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end else if (!reset && div_zero) begin
                chk("div_zero_without_done", 64'(div_zero), 64'd0);
            end
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 255));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        int nb;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // 7 * -3, with busy held through the whole iteration window.
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        nb = 0;
        if (!busy) nb++;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!busy) nb++;
        end
        chk("busy_window", 64'(nb), 64'd0);
        wait_drain();

        issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1); wait_drain();
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_drain();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_drain();
        issue(1'b1, 32'd100, 32'd7, 1'b1);               wait_drain();

        // Preload hi/lo = 0x11/0x22 (102 * 0x2AAAAAAB), then divide by zero.
        issue(1'b0, 32'd102, 32'h2AAA_AAAB, 1'b1);       wait_drain();
        chk("preload_hi", 64'(hi), 64'h11);
        chk("preload_lo", 64'(lo), 64'h22);
        issue(1'b1, 32'd5, 32'd0, 1'b1);                 wait_drain();
        chk("dz_hold_hi", 64'(hi), 64'h11);
        chk("dz_hold_lo", 64'(lo), 64'h22);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_drain();

        // A second start while busy must be ignored.
        issue(1'b0, 32'd3, 32'd4, 1'b1);
        repeat (4) @(negedge clk);
        issue(1'b1, 32'd99, 32'd0, 1'b0);
        wait_drain();

        // Reset mid-operation aborts without a done pulse.
        issue(1'b1, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        issue(1'b1, 32'd1000, 32'd3, 1'b1);              wait_drain();

        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
